// File: rtl/upsample_pkg.sv
// Shared types and width helpers for the 2x nearest-neighbour upsampler.
package upsample_pkg;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    // Counter width for a 0..range-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/upsample_2x_nn_if.sv
// Pixel stream interface: input valid/ready pair and output valid/ready/last pair.
interface upsample_2x_nn_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_ready;
    logic                  o_last;

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_last
    );

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/upsample_row_ram.sv
// Single-row pixel store: one synchronous write port, one asynchronous read port, no reset.
module upsample_row_ram
    import upsample_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [cnt_width(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [cnt_width(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/upsample_2x_nn.sv
// 2x nearest-neighbour upsampler: even output rows duplicate live input pixels,
// odd output rows replay the row buffer.
module upsample_2x_nn
    import upsample_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int IMAGE_WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    upsample_2x_nn_if.slave  bus
);

    localparam int            CW       = cnt_width(IMAGE_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_WIDTH - 1);

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic                  phase;
    logic                  advance;
    logic                  beat;
    logic                  take_input;
    logic                  row_end;
    logic                  frame_end;
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (row_end) begin
            next_state = (state == S_FILL) ? S_REPLAY : S_FILL;
        end
    end

    // A beat is emitted whenever the output register may advance and has something to show:
    // replay always does, fill does on its second copy or when a new pixel arrives.
    always_comb begin
        advance    = !out_valid || bus.o_ready;
        take_input = (state == S_FILL) && !phase && advance && bus.i_valid;
        beat       = advance && ((state == S_REPLAY) || phase || bus.i_valid);
        row_end    = beat && phase && (col == LAST_IDX);
        frame_end  = row_end && (state == S_REPLAY) && (row == LAST_IDX);
    end

    assign bus.i_ready = (state == S_FILL) && !phase && advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            phase <= 1'b0;
        end else if (beat) begin
            phase <= !phase;
            if (phase) begin
                col <= row_end ? '0 : col + 1'b1;
            end
            if (frame_end) begin
                row <= '0;
            end else if (row_end && (state == S_REPLAY)) begin
                row <= row + 1'b1;
            end
        end
    end

    // The fill second copy keeps o_data as-is, since it already holds the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= beat;
            out_last  <= frame_end;
            if (beat) begin
                if (state == S_REPLAY) begin
                    out_data <= ram_rdata;
                end else if (!phase) begin
                    out_data <= bus.i_data;
                end
            end
        end
    end

    assign bus.o_valid = out_valid;
    assign bus.o_last  = out_last;
    assign bus.o_data  = out_data;

    upsample_row_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMAGE_WIDTH)
    ) u_row_ram (
        .clk   (clk),
        .we    (take_input),
        .waddr (col),
        .wdata (bus.i_data),
        .raddr (col),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_upsample_2x_nn.sv
// Directed bench for upsample_2x_nn at DATA_WIDTH=32, IMAGE_WIDTH=2.
module tb_upsample_2x_nn;

    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    upsample_2x_nn_if #(.DATA_WIDTH(DW)) bus ();

    upsample_2x_nn #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] in_pix     [16];
    logic [DW-1:0] cap_data   [64];
    logic          cap_last   [64];
    int            cap_cycle  [64];
    logic          ready_trace[64];
    logic [DW-1:0] stall_data [16];
    logic          stall_valid[16];
    int            n_cap;
    int            idle_cnt;
    int            stall_done;
    logic          timed_out;
    logic          rst_valid;
    logic          rst_last;
    logic [DW-1:0] rst_data;

    // Source pixel index of each beat in a 4x4 output frame built from a 2x2 input frame.
    int exp_idx   [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
    bit exp_ready [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic load_pixels(input logic [DW-1:0] base);
        for (int i = 0; i < 16; i++) begin
            in_pix[i] = base + DW'(i);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives the input stream and captures output beats; entered and left just after a rising edge.
    task automatic run_stream(input int n_in, input int n_out, input int gap_after,
                              input int gap_len, input int stall_beat, input int stall_len,
                              input int rst_after, input int max_cycles);
        int in_idx;
        int cyc;
        int gap_left;
        logic accept;
        in_idx     = 0;
        cyc        = 0;
        gap_left   = 0;
        n_cap      = 0;
        idle_cnt   = 0;
        stall_done = 0;
        timed_out  = 1'b0;
        bus.o_ready = 1'b1;
        bus.i_valid = (n_in > 0);
        bus.i_data  = in_pix[0];
        while (n_cap < n_out) begin
            if (cyc >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            if (cyc < 64) ready_trace[cyc] = bus.i_ready;
            if (!bus.o_valid && n_cap == 2) idle_cnt++;
            if (!bus.o_ready && stall_done < 16) begin
                stall_data[stall_done]  = bus.o_data;
                stall_valid[stall_done] = bus.o_valid;
                stall_done++;
            end
            accept = bus.i_valid && bus.i_ready;
            if (bus.o_valid && bus.o_ready && n_cap < 64) begin
                cap_data[n_cap]  = bus.o_data;
                cap_last[n_cap]  = bus.o_last;
                cap_cycle[n_cap] = cyc;
                n_cap++;
            end
            if (rst_after > 0 && n_cap == rst_after) begin
                rst_n = 1'b0;
                #1;
                rst_valid = bus.o_valid;
                rst_last  = bus.o_last;
                rst_data  = bus.o_data;
                break;
            end
            if (accept) begin
                if (in_idx == gap_after) gap_left = gap_len;
                in_idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (gap_left > 0) begin
                bus.i_valid = 1'b0;
                gap_left--;
            end else if (in_idx < n_in) begin
                bus.i_valid = 1'b1;
                bus.i_data  = in_pix[in_idx];
            end else begin
                bus.i_valid = 1'b0;
            end
            bus.o_ready = !(bus.o_valid && n_cap == stall_beat && stall_done < stall_len);
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_o_valid: got %b want 0", bus.o_valid);
        end
        total++;
        if (bus.o_data !== '0) begin
            bad++; $display("[TB] FAIL reset_o_data: got %h want 0", bus.o_data);
        end
        total++;
        if (bus.o_last !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_o_last: got %b want 0", bus.o_last);
        end
        total++;
        if (bus.i_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_i_ready: got %b want 1", bus.i_ready);
        end
    endtask

    task automatic test_basic_frame();
        load_pixels(32'hA000_0000);
        do_reset();
        run_stream(4, 16, -1, 0, -1, 0, 0, 200);
        total++;
        if (timed_out !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_timeout: got %0d beats want 16", n_cap);
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (cap_data[k] !== in_pix[exp_idx[k]]) begin
                bad++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", k, cap_data[k], in_pix[exp_idx[k]]);
            end
            total++;
            if (cap_last[k] !== (k == 15)) begin
                bad++; $display("[TB] FAIL basic_last[%0d]: got %b want %b", k, cap_last[k], (k == 15));
            end
        end
        total++;
        if (cap_cycle[15] - cap_cycle[0] !== 15) begin
            bad++; $display("[TB] FAIL basic_throughput: got %0d want 15", cap_cycle[15] - cap_cycle[0]);
        end
    endtask

    task automatic test_stall();
        load_pixels(32'hB000_0000);
        do_reset();
        run_stream(4, 16, -1, 0, 2, 3, 0, 200);
        total++;
        if (timed_out !== 1'b0 || stall_done !== 3) begin
            bad++; $display("[TB] FAIL stall_cycles: got %0d want 3", stall_done);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (stall_data[k] !== in_pix[1] || stall_valid[k] !== 1'b1) begin
                bad++; $display("[TB] FAIL stall_hold[%0d]: got %h/%b want %h/1", k, stall_data[k], stall_valid[k], in_pix[1]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (cap_data[k] !== in_pix[exp_idx[k]] || cap_last[k] !== (k == 15)) begin
                bad++; $display("[TB] FAIL stall_beat[%0d]: got %h/%b want %h/%b", k, cap_data[k], cap_last[k], in_pix[exp_idx[k]], (k == 15));
            end
        end
    endtask

    task automatic test_ready_pattern();
        load_pixels(32'hC000_0000);
        do_reset();
        run_stream(8, 32, -1, 0, -1, 0, 0, 300);
        total++;
        if (timed_out !== 1'b0) begin
            bad++; $display("[TB] FAIL ready_timeout: got %0d beats want 32", n_cap);
        end
        for (int c = 0; c < 32; c++) begin
            total++;
            if (ready_trace[c] !== exp_ready[c % 8]) begin
                bad++; $display("[TB] FAIL ready_pattern[%0d]: got %b want %b", c, ready_trace[c], exp_ready[c % 8]);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_pixels(32'hD000_0000);
        do_reset();
        run_stream(8, 32, -1, 0, -1, 0, 0, 300);
        total++;
        if (timed_out !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_timeout: got %0d beats want 32", n_cap);
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (cap_data[16*f+k] !== in_pix[4*f+exp_idx[k]] || cap_last[16*f+k] !== (k == 15)) begin
                    bad++; $display("[TB] FAIL b2b_beat[%0d]: got %h/%b want %h/%b", 16*f+k, cap_data[16*f+k],
                                    cap_last[16*f+k], in_pix[4*f+exp_idx[k]], (k == 15));
                end
            end
        end
        total++;
        if (cap_cycle[16] !== cap_cycle[15] + 1) begin
            bad++; $display("[TB] FAIL b2b_no_idle: got cycle %0d want %0d", cap_cycle[16], cap_cycle[15] + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        load_pixels(32'hE000_0000);
        do_reset();
        run_stream(4, 16, -1, 0, -1, 0, 6, 200);
        total++;
        if (rst_valid !== 1'b0 || rst_last !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_valid: got %b/%b want 0/0", rst_valid, rst_last);
        end
        total++;
        if (rst_data !== '0) begin
            bad++; $display("[TB] FAIL midreset_data: got %h want 0", rst_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_pixels(32'hE100_0000);
        run_stream(4, 16, -1, 0, -1, 0, 0, 200);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (cap_data[k] !== in_pix[exp_idx[k]] || cap_last[k] !== (k == 15)) begin
                bad++; $display("[TB] FAIL midreset_beat[%0d]: got %h/%b want %h/%b", k, cap_data[k], cap_last[k], in_pix[exp_idx[k]], (k == 15));
            end
        end
    endtask

    task automatic test_input_gap();
        load_pixels(32'hF000_0000);
        do_reset();
        run_stream(4, 16, 0, 5, -1, 0, 0, 200);
        total++;
        if (idle_cnt !== 4) begin
            bad++; $display("[TB] FAIL gap_idle: got %0d want 4", idle_cnt);
        end
        total++;
        if (cap_cycle[2] - cap_cycle[1] !== 5) begin
            bad++; $display("[TB] FAIL gap_spacing: got %0d want 5", cap_cycle[2] - cap_cycle[1]);
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (cap_data[k] !== in_pix[exp_idx[k]] || cap_last[k] !== (k == 15)) begin
                bad++; $display("[TB] FAIL gap_beat[%0d]: got %h/%b want %h/%b", k, cap_data[k], cap_last[k], in_pix[exp_idx[k]], (k == 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_ready_pattern();
        test_back_to_back();
        test_reset_mid_frame();
        test_input_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
